mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction fetch requester (IF) and the load/store requester (LS).
- Sits between instruction_fetch / LSU and the memory array.
- Accepts one request at a time, issues it to memory, waits a fixed read latency, then returns a one-cycle response to the requester that was granted.
- Default arbitration is fixed priority, LS over IF.

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the instruction fetch requester (IF) and the
//   load/store requester (LS). Only one transaction is in flight at a time. Each one is
//   accepted, issued to memory for one cycle, and waited out for MEM_LAT cycles. The
//   read data is then returned to the granted requester as a one-cycle response pulse.
//
//   Arbitration: fixed priority, LS over IF.
//   Build option: define ARB_RR_EN to switch to round-robin arbitration between IF and LS.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   if_req_*          IF read request (valid/addr) and ready handshake
//   if_rsp_*          IF response pulse and held read data
//   ls_req_*          LS request (valid/addr/we/wdata/wstrb) and ready handshake
//   ls_rsp_*          LS response pulse and held read data (0 for writes)
//   mem_*             memory strobe, byte write enables, address, write data, read data
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                ls_req_valid,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic                ls_req_we,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wstrb,
    output logic                ls_req_ready,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rsp_data,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                gnt_ls_q, gnt_ls_d;   // owner of the in-flight transaction
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic [DATA_W-1:0]   ls_data_q, ls_data_d;

    logic accept_state;
    logic grant_ls;
    logic if_acc;
    logic ls_acc;

    assign accept_state = (state_q == StIdle) || (state_q == StResp);

`ifdef ARB_RR_EN
    logic last_ls_q;   // 1: last accept went to LS, 0: to IF

    // On contention, the requester that did not win last time gets the grant.
    assign grant_ls = ls_req_valid && (!if_req_valid || !last_ls_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_ls_q <= 1'b0;
        end else if (if_acc || ls_acc) begin
            last_ls_q <= ls_acc;
        end
    end
`else
    assign grant_ls = ls_req_valid;
`endif

    assign ls_req_ready = accept_state && grant_ls;
    assign if_req_ready = accept_state && if_req_valid && !grant_ls;
    assign ls_acc       = ls_req_valid && ls_req_ready;
    assign if_acc       = if_req_valid && if_req_ready;

    assign if_rsp_data  = if_data_q;
    assign ls_rsp_data  = ls_data_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        gnt_ls_d     = gnt_ls_q;
        if_data_d    = if_data_q;
        ls_data_d    = ls_data_q;
        mem_en       = 1'b0;
        mem_we       = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if_rsp_valid = 1'b0;
        ls_rsp_valid = 1'b0;

        unique case (state_q)
            StIdle, StResp: begin
                if (state_q == StResp) begin
                    if_rsp_valid = !gnt_ls_q;
                    ls_rsp_valid = gnt_ls_q;
                end
                if (ls_acc || if_acc) begin
                    addr_d   = ls_acc ? ls_req_addr : if_req_addr;
                    we_d     = ls_acc && ls_req_we;
                    wdata_d  = ls_acc ? ls_req_wdata : '0;
                    wstrb_d  = ls_acc ? ls_req_wstrb : '0;
                    gnt_ls_d = ls_acc;
                    state_d  = StIssue;
                end else begin
                    state_d  = StIdle;
                end
            end
            StIssue: begin
                mem_en    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_we    = we_q ? wstrb_q : '0;
                cnt_d     = CNT_W'(MEM_LAT - 1);
                state_d   = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    // mem_rdata is valid exactly MEM_LAT cycles after the issue cycle.
                    if (gnt_ls_q) begin
                        ls_data_d = we_q ? '0 : mem_rdata;
                    end else begin
                        if_data_d = mem_rdata;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            gnt_ls_q  <= 1'b0;
            if_data_q <= '0;
            ls_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            gnt_ls_q  <= gnt_ls_d;
            if_data_q <= if_data_d;
            ls_data_q <= ls_data_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Instance "a" runs with MEM_LAT=1 and covers reset,
//   single reads, contention, writes, mid-transaction reset and fairness. Instance "b" runs
//   with MEM_LAT=3 and covers back-to-back IF reads. Behavioural memories return a fixed
//   word per address after the instance's latency.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
`ifdef ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance a (MEM_LAT = 1)
    logic          if_req_valid;
    logic [AW-1:0] if_req_addr;
    logic          if_req_ready;
    logic          if_rsp_valid;
    logic [DW-1:0] if_rsp_data;
    logic          ls_req_valid;
    logic [AW-1:0] ls_req_addr;
    logic          ls_req_we;
    logic [DW-1:0] ls_req_wdata;
    logic [SW-1:0] ls_req_wstrb;
    logic          ls_req_ready;
    logic          ls_rsp_valid;
    logic [DW-1:0] ls_rsp_data;
    logic          mem_en;
    logic [SW-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Instance b (MEM_LAT = 3), IF traffic only
    logic          b_if_req_valid;
    logic [AW-1:0] b_if_req_addr;
    logic          b_if_req_ready;
    logic          b_if_rsp_valid;
    logic [DW-1:0] b_if_rsp_data;
    logic          b_ls_req_ready;
    logic          b_ls_rsp_valid;
    logic [DW-1:0] b_ls_rsp_data;
    logic          b_mem_en;
    logic [SW-1:0] b_mem_we;
    logic [AW-1:0] b_mem_addr;
    logic [DW-1:0] b_mem_wdata;
    logic [DW-1:0] b_mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_req_ready (if_req_ready),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .ls_req_valid (ls_req_valid),
        .ls_req_addr  (ls_req_addr),
        .ls_req_we    (ls_req_we),
        .ls_req_wdata (ls_req_wdata),
        .ls_req_wstrb (ls_req_wstrb),
        .ls_req_ready (ls_req_ready),
        .ls_rsp_valid (ls_rsp_valid),
        .ls_rsp_data  (ls_rsp_data),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (b_if_req_valid),
        .if_req_addr  (b_if_req_addr),
        .if_req_ready (b_if_req_ready),
        .if_rsp_valid (b_if_rsp_valid),
        .if_rsp_data  (b_if_rsp_data),
        .ls_req_valid (1'b0),
        .ls_req_addr  ('0),
        .ls_req_we    (1'b0),
        .ls_req_wdata ('0),
        .ls_req_wstrb ('0),
        .ls_req_ready (b_ls_req_ready),
        .ls_rsp_valid (b_ls_rsp_valid),
        .ls_rsp_data  (b_ls_rsp_data),
        .mem_en       (b_mem_en),
        .mem_we       (b_mem_we),
        .mem_addr     (b_mem_addr),
        .mem_wdata    (b_mem_wdata),
        .mem_rdata    (b_mem_rdata)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a == '0) ? 32'h0000_0013 : (32'h1000_0000 | a);
    endfunction

    // Memory models: a has one read stage, b has three; b shows junk unless fed by mem_en.
    logic [DW-1:0] a_pipe = '0;
    logic [DW-1:0] b_pipe [3];
    always @(posedge clk) begin
        if (mem_en) a_pipe <= mem_word(mem_addr);
        b_pipe[0] <= b_mem_en ? mem_word(b_mem_addr) : 32'hBAD0_BAD0;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign mem_rdata   = a_pipe;
    assign b_mem_rdata = b_pipe[2];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_ls_grant(input int k);
        return RrEn ? ((k % 2) == 0) : 1'b1;
    endfunction

    initial begin
        logic exp_ls;
        logic exp_rdy;
        int   idx;

        rst            = 1'b0;
        if_req_valid   = 1'b0;
        if_req_addr    = '0;
        ls_req_valid   = 1'b0;
        ls_req_addr    = '0;
        ls_req_we      = 1'b0;
        ls_req_wdata   = '0;
        ls_req_wstrb   = '0;
        b_if_req_valid = 1'b0;
        b_if_req_addr  = '0;
        b_pipe[0]      = '0;
        b_pipe[1]      = '0;
        b_pipe[2]      = '0;

        // 1: reset state, then a single IF read of address 0
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_if_ready", if_req_ready, 0);
        check_val("rst_ls_ready", ls_req_ready, 0);
        check_val("rst_mem_en", mem_en, 0);
        check_val("rst_mem_we", mem_we, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_mem_wdata", mem_wdata, 0);
        check_val("rst_if_rsp_valid", if_rsp_valid, 0);
        check_val("rst_ls_rsp_valid", ls_rsp_valid, 0);
        check_val("rst_if_rsp_data", if_rsp_data, 0);
        check_val("rst_ls_rsp_data", ls_rsp_data, 0);
        rst = 1'b1;
        tick();

        if_req_valid = 1'b1;
        if_req_addr  = 32'h0;
        #1;
        check_val("t1_if_ready", if_req_ready, 1);
        check_val("t1_ls_ready", ls_req_ready, 0);
        tick();
        if_req_valid = 1'b0;
        #1;
        check_val("t1_mem_en", mem_en, 1);
        check_val("t1_mem_addr", mem_addr, 32'h0);
        check_val("t1_mem_we", mem_we, 0);
        check_val("t1_ls_rsp_valid_a", ls_rsp_valid, 0);
        tick();
        check_val("t1_mem_en_wait", mem_en, 0);
        check_val("t1_if_rsp_early", if_rsp_valid, 0);
        tick();
        check_val("t1_if_rsp_valid", if_rsp_valid, 1);
        check_val("t1_if_rsp_data", if_rsp_data, 32'h0000_0013);
        check_val("t1_ls_rsp_valid_b", ls_rsp_valid, 0);
        tick();
        check_val("t1_if_rsp_pulse", if_rsp_valid, 0);
        check_val("t1_if_rsp_hold", if_rsp_data, 32'h0000_0013);

        // 2: simultaneous IF/LS reads, LS first then IF in the LS response cycle
        if_req_valid = 1'b1;
        if_req_addr  = 32'h4;
        ls_req_valid = 1'b1;
        ls_req_addr  = 32'h100;
        #1;
        check_val("t2_ls_ready", ls_req_ready, 1);
        check_val("t2_if_ready", if_req_ready, 0);
        tick();
        ls_req_valid = 1'b0;
        #1;
        check_val("t2_mem_addr_ls", mem_addr, 32'h100);
        check_val("t2_if_ready_issue", if_req_ready, 0);
        tick();
        check_val("t2_if_ready_wait", if_req_ready, 0);
        tick();
        check_val("t2_ls_rsp_valid", ls_rsp_valid, 1);
        check_val("t2_ls_rsp_data", ls_rsp_data, 32'h1000_0100);
        check_val("t2_if_rsp_quiet", if_rsp_valid, 0);
        check_val("t2_if_ready_resp", if_req_ready, 1);
        tick();
        if_req_valid = 1'b0;
        #1;
        check_val("t2_mem_en_if", mem_en, 1);
        check_val("t2_mem_addr_if", mem_addr, 32'h4);
        check_val("t2_ls_rsp_pulse", ls_rsp_valid, 0);
        tick();
        tick();
        check_val("t2_if_rsp_valid", if_rsp_valid, 1);
        check_val("t2_if_rsp_data", if_rsp_data, 32'h1000_0004);
        check_val("t2_ls_rsp_quiet", ls_rsp_valid, 0);
        tick();

        // 3: LS partial write
        ls_req_valid = 1'b1;
        ls_req_we    = 1'b1;
        ls_req_addr  = 32'h200;
        ls_req_wdata = 32'hDEAD_BEEF;
        ls_req_wstrb = 4'h3;
        #1;
        check_val("t3_ls_ready", ls_req_ready, 1);
        tick();
        ls_req_valid = 1'b0;
        ls_req_we    = 1'b0;
        #1;
        check_val("t3_mem_en", mem_en, 1);
        check_val("t3_mem_we", mem_we, 4'h3);
        check_val("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check_val("t3_mem_addr", mem_addr, 32'h200);
        tick();
        tick();
        check_val("t3_ls_rsp_valid", ls_rsp_valid, 1);
        check_val("t3_ls_rsp_data", ls_rsp_data, 0);
        check_val("t3_if_rsp_quiet", if_rsp_valid, 0);
        tick();

        // 4: back-to-back IF reads on the MEM_LAT=3 instance, accepts 5 cycles apart
        idx = 0;
        for (int c = 0; c < 17; c++) begin
            b_if_req_valid = (idx < 3);
            b_if_req_addr  = AW'(idx * 4);
            #1;
            exp_rdy = ((c % 5) == 0) && (c <= 10);
            check_val($sformatf("t4_ready_c%0d", c), b_if_req_ready, exp_rdy);
            check_val($sformatf("t4_rsp_valid_c%0d", c), b_if_rsp_valid,
                      (c == 5) || (c == 10) || (c == 15));
            check_val($sformatf("t4_ls_rsp_c%0d", c), b_ls_rsp_valid, 0);
            if ((c == 5) || (c == 10) || (c == 15)) begin
                check_val($sformatf("t4_rsp_data_c%0d", c), b_if_rsp_data,
                          mem_word(AW'((c / 5 - 1) * 4)));
            end
            if (((c % 5) == 1) && (c <= 11)) begin
                check_val($sformatf("t4_mem_en_c%0d", c), b_mem_en, 1);
                check_val($sformatf("t4_mem_addr_c%0d", c), b_mem_addr, AW'((c / 5) * 4));
                check_val($sformatf("t4_mem_we_c%0d", c), b_mem_we, 0);
                check_val($sformatf("t4_mem_wdata_c%0d", c), b_mem_wdata, 0);
            end
            if (exp_rdy) idx++;
            tick();
        end
        check_val("t4_ls_ready", b_ls_req_ready, 0);
        check_val("t4_ls_rsp_data", b_ls_rsp_data, 0);

        // 5: reset during WAIT drops the transaction
        if_req_valid = 1'b1;
        if_req_addr  = 32'h8;
        #1;
        check_val("t5_if_ready", if_req_ready, 1);
        tick();
        if_req_valid = 1'b0;
        #1;
        check_val("t5_mem_en_issue", mem_en, 1);
        tick();
        rst = 1'b0;
        #1;
        check_val("t5_rst_mem_en", mem_en, 0);
        check_val("t5_rst_if_rsp_valid", if_rsp_valid, 0);
        check_val("t5_rst_ls_rsp_valid", ls_rsp_valid, 0);
        check_val("t5_rst_if_rsp_data", if_rsp_data, 0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_val($sformatf("t5_no_rsp_c%0d", c), if_rsp_valid, 0);
            check_val($sformatf("t5_no_mem_en_c%0d", c), mem_en, 0);
            tick();
        end
        if_req_valid = 1'b1;
        if_req_addr  = 32'h4;
        #1;
        check_val("t5_next_ready", if_req_ready, 1);
        tick();
        if_req_valid = 1'b0;
        tick();
        tick();
        check_val("t5_next_rsp_valid", if_rsp_valid, 1);
        check_val("t5_next_rsp_data", if_rsp_data, 32'h1000_0004);
        tick();

        // 6: both requesters continuously valid
        if_req_valid = 1'b1;
        if_req_addr  = 32'h4;
        ls_req_valid = 1'b1;
        ls_req_addr  = 32'h100;
        for (int c = 0; c <= 12; c++) begin
            #1;
            if (((c % 3) == 0) && (c < 12)) begin
                exp_ls = exp_ls_grant(c / 3);
                check_val($sformatf("t6_ls_ready_g%0d", c / 3), ls_req_ready, exp_ls);
                check_val($sformatf("t6_if_ready_g%0d", c / 3), if_req_ready, !exp_ls);
            end
            if (((c % 3) == 0) && (c > 0)) begin
                exp_ls = exp_ls_grant(c / 3 - 1);
                check_val($sformatf("t6_ls_rsp_g%0d", c / 3 - 1), ls_rsp_valid, exp_ls);
                check_val($sformatf("t6_if_rsp_g%0d", c / 3 - 1), if_rsp_valid, !exp_ls);
            end
            tick();
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
